picobus_decoder: RTL and testbench

Parametrised address decoder and response mux for the picorv32 native memory bus: one master, N_SLAVES slave ports. It replaces hard-wired two-way flash/RAM decode at SoC top level. Each slave owns a region selected by configurable address bits. The block registers the handshake, completes unmapped and stalled accesses with an error word instead of hanging the CPU, and reports faults on an IRQ-capable pulse plus a captured address.

---
 rtl/picobus_pkg.sv | 20 ++
 rtl/picobus_if.sv | 44 ++++
 rtl/picobus_region_match.sv | 30 +++
 rtl/picobus_decoder.sv | 166 ++++++++++++++++
 tb/tb_picobus_decoder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/picobus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : picobus_pkg
// Purpose  : Shared types and constants for the picobus address decoder.
// Revision : 1.0
// ============================================================================
package picobus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          N_SLAVES_MAX      = 8;

endpackage
`default_nettype wire

// File: rtl/picobus_if.sv
`default_nettype none
// ============================================================================
// Module   : picobus_if
// Purpose  : picorv32 native bus, fanned-out slave ports and fault report.
// Revision : 1.0
// ============================================================================
interface picobus_if #(
  parameter int N_SLAVES = 4
) ();

  logic                   m_valid;
  logic                   m_instr;
  logic [31:0]            m_addr;
  logic [31:0]            m_wdata;
  logic [3:0]             m_wstrb;
  logic                   m_ready;
  logic [31:0]            m_rdata;

  logic [N_SLAVES-1:0]    s_valid;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_wstrb;
  logic [N_SLAVES-1:0]    s_ready;
  logic [N_SLAVES*32-1:0] s_rdata;

  logic                   err_irq;
  logic [31:0]            err_addr;
  logic                   err_instr;

  // Decoder view: bus slave towards the CPU, request source towards the slaves
  modport slave (
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb,
    output err_irq, err_addr, err_instr
  );

  modport master (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb,
    input  err_irq, err_addr, err_instr
  );

endinterface
`default_nettype wire

// File: rtl/picobus_region_match.sv
`default_nettype none
// ============================================================================
// Module   : picobus_region_match
// Purpose  : Priority match of the region-select field; lowest slave index wins.
// Revision : 1.0
// ============================================================================
module picobus_region_match #(
  parameter int                        N_SLAVES = 4,
  parameter int                        SW       = 4,
  parameter logic [N_SLAVES*SW-1:0]    REGIONS  = '0
) (
  input  logic [SW-1:0]       i_sel,
  output logic [N_SLAVES-1:0] o_onehot,
  output logic                o_hit
);

  logic [N_SLAVES-1:0] w_eq;
  logic [N_SLAVES-1:0] w_neg;

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_cmp
    assign w_eq[gi] = (i_sel == REGIONS[gi*SW +: SW]);
  end

  // Two's complement AND isolates the lowest set bit
  assign w_neg    = -w_eq;
  assign o_onehot = w_eq & w_neg;
  assign o_hit    = |w_eq;

endmodule
`default_nettype wire

// File: rtl/picobus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : picobus_decoder
// Purpose  : Registered address decoder / response mux for the picorv32 bus.
//            Define BUS_TIMEOUT_EN to add the stalled-slave watchdog.
// Revision : 1.0
// ============================================================================
module picobus_decoder
  import picobus_pkg::*;
#(
  parameter int                                   N_SLAVES       = 4,
  parameter int                                   SEL_HI         = 31,
  parameter int                                   SEL_LO         = 28,
  parameter logic [N_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLAVE_REGION  = {4'h4, 4'h3, 4'h2, 4'h1},
  parameter int                                   TIMEOUT_CYCLES = 256,
  parameter logic [31:0]                          ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic      clk,
  input  logic      resetn,
  picobus_if.slave  bus
);

  localparam int SW    = SEL_HI - SEL_LO + 1;
  localparam int N_EFF = (N_SLAVES < N_SLAVES_MAX) ? N_SLAVES : N_SLAVES_MAX;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_SLAVES-1:0] w_match;
  logic                w_hit;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;
  logic                w_expired;

  logic [N_SLAVES-1:0] r_s_valid;
  logic [31:0]         r_s_addr;
  logic [31:0]         r_s_wdata;
  logic [3:0]          r_s_wstrb;
  logic                r_instr;
  logic                r_m_ready;
  logic [31:0]         r_m_rdata;
  logic                r_err_irq;
  logic [31:0]         r_err_addr;
  logic                r_err_instr;

  picobus_region_match #(
    .N_SLAVES (N_SLAVES),
    .SW       (SW),
    .REGIONS  (SLAVE_REGION)
  ) u_match (
    .i_sel    (bus.m_addr[SEL_HI:SEL_LO]),
    .o_onehot (w_match),
    .o_hit    (w_hit)
  );

  // Only the selected slave may complete the access
  assign w_sel_ready = |(bus.s_ready & r_s_valid);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < N_EFF; i++) begin
      if (r_s_valid[i]) w_sel_rdata = bus.s_rdata[i*32 +: 32];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state != ST_ACTIVE) begin
      r_cnt <= '0;
    end else if (!w_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  // No watchdog: the comparison is constant false and adds no logic
  assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.m_valid) w_state_nxt = w_hit ? ST_ACTIVE : ST_FAULT;
      ST_ACTIVE: begin
        if (w_sel_ready)    w_state_nxt = ST_RESP;
        else if (w_expired) w_state_nxt = ST_FAULT;
      end
      ST_RESP:   w_state_nxt = ST_IDLE;
      ST_FAULT:  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s_valid   <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wstrb   <= '0;
      r_instr     <= 1'b0;
      r_m_ready   <= 1'b0;
      r_m_rdata   <= '0;
      r_err_irq   <= 1'b0;
      r_err_addr  <= '0;
      r_err_instr <= 1'b0;
    end else begin
      r_m_ready <= 1'b0;
      r_err_irq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.m_valid && w_hit) begin
            r_s_valid <= w_match;
            r_s_addr  <= bus.m_addr;
            r_s_wdata <= bus.m_wdata;
            r_s_wstrb <= bus.m_wstrb;
            r_instr   <= bus.m_instr;
          end else if (bus.m_valid) begin
            r_m_ready   <= 1'b1;
            r_m_rdata   <= ERR_RDATA;
            r_err_irq   <= 1'b1;
            r_err_addr  <= bus.m_addr;
            r_err_instr <= bus.m_instr;
          end
        end
        ST_ACTIVE: begin
          // A ready arriving on the expiry cycle still completes normally
          if (w_sel_ready) begin
            r_s_valid <= '0;
            r_m_ready <= 1'b1;
            r_m_rdata <= w_sel_rdata;
          end else if (w_expired) begin
            r_s_valid   <= '0;
            r_m_ready   <= 1'b1;
            r_m_rdata   <= ERR_RDATA;
            r_err_irq   <= 1'b1;
            r_err_addr  <= r_s_addr;
            r_err_instr <= r_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_ready   = r_m_ready;
  assign bus.m_rdata   = r_m_rdata;
  assign bus.s_valid   = r_s_valid;
  assign bus.s_addr    = r_s_addr;
  assign bus.s_wdata   = r_s_wdata;
  assign bus.s_wstrb   = r_s_wstrb;
  assign bus.err_irq   = r_err_irq;
  assign bus.err_addr  = r_err_addr;
  assign bus.err_instr = r_err_instr;

endmodule
`default_nettype wire

// File: tb/tb_picobus_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_picobus_decoder
// Purpose  : Self-checking bench: transaction-level model plus directed pins.
// Revision : 1.0
// ============================================================================
module tb_picobus_decoder;

  localparam int          N      = 4;
  localparam int          T      = 8;
  localparam logic [15:0] REGION = {4'h2, 4'h3, 4'h2, 4'h1};
  localparam logic [31:0] ERRW   = 32'hDEAD_BEEF;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  picobus_if #(.N_SLAVES(N)) bus ();

  picobus_decoder #(
    .N_SLAVES       (N),
    .SEL_HI         (31),
    .SEL_LO         (28),
    .SLAVE_REGION   (REGION),
    .TIMEOUT_CYCLES (T),
    .ERR_RDATA      (ERRW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int codes [N] = '{1, 2, 3, 2};

  int          cyc      = -1;
  int          exp_tgt  = -1;
  int          exp_done = 0;
  bit          exp_fault = 1'b0;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_err_addr  = '0;
  logic        exp_err_instr = 1'b0;
  bit          cmp_en = 1'b0;

  int          obs_done, obs_ready_cnt, obs_irq;
  logic [31:0] obs_rdata, obs_wdata;
  logic [3:0]  obs_wstrb;
  logic [N-1:0] obs_sv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic int model_target(input logic [31:0] a);
    for (int i = 0; i < N; i++) if (codes[i] == int'(a[31:28])) return i;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_ready"},   32'(bus.m_ready),   32'd0);
    chk({tag, "_m_rdata"},   bus.m_rdata,        32'd0);
    chk({tag, "_s_valid"},   32'(bus.s_valid),   32'd0);
    chk({tag, "_s_addr"},    bus.s_addr,         32'd0);
    chk({tag, "_s_wdata"},   bus.s_wdata,        32'd0);
    chk({tag, "_s_wstrb"},   32'(bus.s_wstrb),   32'd0);
    chk({tag, "_err_irq"},   32'(bus.err_irq),   32'd0);
    chk({tag, "_err_addr"},  bus.err_addr,       32'd0);
    chk({tag, "_err_instr"}, 32'(bus.err_instr), 32'd0);
  endtask

  // Single compare process: expectations come from the transaction model
  always @(negedge clk) begin : p_cmp
    logic [N-1:0] e_sv;
    logic         e_rdy;
    if (cmp_en) begin
      e_sv = '0;
      if (exp_tgt >= 0 && cyc >= 1 && cyc <= exp_done - 1) e_sv[exp_tgt] = 1'b1;
      e_rdy = (cyc > 0) && (cyc == exp_done);
      chk("s_valid", 32'(bus.s_valid), 32'(e_sv));
      chk("m_ready", 32'(bus.m_ready), 32'(e_rdy));
      chk("err_irq", 32'(bus.err_irq), 32'(e_rdy && exp_fault));
      if (e_sv != '0) begin
        chk("s_addr",  bus.s_addr,        exp_addr);
        chk("s_wdata", bus.s_wdata,       exp_wdata);
        chk("s_wstrb", 32'(bus.s_wstrb),  32'(exp_wstrb));
      end
      if (e_rdy) chk("m_rdata", bus.m_rdata, exp_fault ? ERRW : exp_rdata);
      chk("err_addr",  bus.err_addr,        exp_err_addr);
      chk("err_instr", 32'(bus.err_instr),  32'(exp_err_instr));
      obs_sv = obs_sv | bus.s_valid;
      if (bus.s_valid != '0) begin
        obs_wstrb = bus.s_wstrb;
        obs_wdata = bus.s_wdata;
      end
      if (bus.m_ready) begin
        obs_ready_cnt++;
        obs_done  = cyc;
        obs_rdata = bus.m_rdata;
      end
      if (bus.err_irq) obs_irq++;
    end
  end

  task automatic drive_slaves(input int c, input int kready, input logic [31:0] rd,
                              input logic [N-1:0] frc);
    logic [N-1:0] oh, rdy;
    oh = '0;
    if (exp_tgt >= 0) oh[exp_tgt] = 1'b1;
    rdy = (N'($urandom) | frc) & ~oh;
    if (exp_tgt >= 0 && c >= kready && c <= exp_done) rdy = rdy | oh;
    bus.s_ready = rdy;
    for (int i = 0; i < N; i++) bus.s_rdata[i*32 +: 32] = (i == exp_tgt) ? rd : $urandom;
  endtask

  // One access; lat = cycles after s_valid before the target raises s_ready
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic ins, input int lat, input logic [31:0] rd,
                     input logic [N-1:0] frc);
    int kready;
    @(posedge clk); #1;
    exp_addr  = a;
    exp_wdata = wd;
    exp_wstrb = ws;
    exp_rdata = rd;
    exp_tgt   = model_target(a);
    kready    = 1 + lat;
    if (exp_tgt < 0) begin
      exp_fault = 1'b1; exp_done = 1;
    end else if (TO_EN && kready > T + 1) begin
      exp_fault = 1'b1; exp_done = T + 2;
    end else begin
      exp_fault = 1'b0; exp_done = kready + 1;
    end
    obs_sv = '0; obs_done = -1; obs_ready_cnt = 0; obs_irq = 0;
    obs_rdata = '0; obs_wdata = '0; obs_wstrb = '0;
    bus.m_valid = 1'b1;
    bus.m_addr  = a;
    bus.m_wdata = wd;
    bus.m_wstrb = ws;
    bus.m_instr = ins;
    cyc = 0;
    drive_slaves(0, kready, rd, frc);
    for (int c = 1; c <= exp_done; c++) begin
      @(posedge clk); #1;
      cyc = c;
      if (c == exp_done && exp_fault) begin
        exp_err_addr  = a;
        exp_err_instr = ins;
      end
      drive_slaves(c, kready, rd, frc);
    end
    @(posedge clk); #1;
    bus.m_valid = 1'b0;
    bus.s_ready = '0;
    cyc     = -1;
    exp_tgt = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.m_valid = 1'b0;
    bus.m_instr = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_ready = '0;
    bus.s_rdata = '0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    cmp_en = 1'b1;

    txn(32'h2000_0010, 32'h0, 4'b0000, 1'b0, 1, 32'h1234_5678, '0);
    chk("t1_sv",    32'(obs_sv),        32'h2);
    chk("t1_done",  32'(obs_done),      32'd3);
    chk("t1_rdata", obs_rdata,          32'h1234_5678);
    chk("t1_count", 32'(obs_ready_cnt), 32'd1);

    txn(32'h1000_0004, 32'hAABB_CCDD, 4'b0011, 1'b0, 3, 32'h0BAD_0001, '0);
    chk("t2_sv",    32'(obs_sv),        32'h1);
    chk("t2_wstrb", 32'(obs_wstrb),     32'h3);
    chk("t2_wdata", obs_wdata,          32'hAABB_CCDD);
    chk("t2_count", 32'(obs_ready_cnt), 32'd1);

    txn(32'h7000_0000, 32'h0, 4'b0000, 1'b1, 0, 32'h0, '0);
    chk("t3_sv",       32'(obs_sv),        32'h0);
    chk("t3_done",     32'(obs_done),      32'd1);
    chk("t3_rdata",    obs_rdata,          32'hDEAD_BEEF);
    chk("t3_irq",      32'(obs_irq),       32'd1);
    chk("t3_err_addr", bus.err_addr,       32'h7000_0000);
    chk("t3_err_ins",  32'(bus.err_instr), 32'd1);

`ifdef BUS_TIMEOUT_EN
    txn(32'h3000_0020, 32'h0, 4'b0000, 1'b0, 40, 32'h5555_5555, '0);
    chk("t4_sv",       32'(obs_sv),   32'h4);
    chk("t4_done",     32'(obs_done), 32'd10);
    chk("t4_rdata",    obs_rdata,     32'hDEAD_BEEF);
    chk("t4_irq",      32'(obs_irq),  32'd1);
    chk("t4_err_addr", bus.err_addr,  32'h3000_0020);
`else
    txn(32'h3000_0020, 32'h0, 4'b0000, 1'b0, 12, 32'h5555_5555, '0);
    chk("t4_sv",    32'(obs_sv),   32'h4);
    chk("t4_done",  32'(obs_done), 32'd14);
    chk("t4_rdata", obs_rdata,     32'h5555_5555);
    chk("t4_irq",   32'(obs_irq),  32'd0);
`endif

    txn(32'h2000_0000, 32'h0, 4'b0000, 1'b0, 3, 32'h0F0F_1234, 4'b1000);
    chk("t5_sv",    32'(obs_sv),   32'h2);
    chk("t5_done",  32'(obs_done), 32'd5);
    chk("t5_rdata", obs_rdata,     32'h0F0F_1234);

    // Asynchronous reset in the middle of a stalled access
    cmp_en = 1'b0;
    @(posedge clk); #1;
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h2000_0040;
    bus.s_ready = '0;
    @(posedge clk); #1;
    bus.m_valid = 1'b0;
    chk("t6_pre_sv", 32'(bus.s_valid), 32'h2);
    #2 resetn = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (3) @(posedge clk);
    #1 chk_all_zero("inrst");
    resetn        = 1'b1;
    exp_err_addr  = '0;
    exp_err_instr = 1'b0;
    cyc           = -1;
    cmp_en        = 1'b1;
    txn(32'h1000_0100, 32'h0, 4'b0000, 1'b0, 0, 32'hCAFE_F00D, '0);
    chk("t6_done",  32'(obs_done),      32'd2);
    chk("t6_rdata", obs_rdata,          32'hCAFE_F00D);
    chk("t6_count", 32'(obs_ready_cnt), 32'd1);

    for (int n = 0; n < 150; n++) begin
      logic [3:0]  nib;
      logic [31:0] a;
      nib = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      a   = {nib, 28'($urandom)};
      txn(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 12), $urandom, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
